// File: rtl/adder_carry_serial.sv
// rtl/adder_carry_serial.sv - chunk-serial add/subtract unit with carry-in, carry-out and signed overflow
//
// Adds or subtracts two N-bit operands K bits per clock, LSB chunk first, using one
// K-bit adder and a carry register.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset, clears all state and the held result
//   start      operation request, accepted only while ready=1
//   sub        0: a+b+cin, 1: a-b (cin ignored), captured with start
//   cin        carry-in for add mode, captured with start
//   a, b       N-bit operands, captured with start
//   ready      high while idle
//   done_tick  one-cycle pulse, sum/cout/ovf updated in this cycle
//   sum        N-bit result, held until the next completion or reset
//   cout       carry out of bit N-1 (sub mode: 1 = no borrow)
//   ovf        signed two's-complement overflow
module adder_carry_serial #(
   parameter int N = 32,
   parameter int K = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         sub,
   input  logic         cin,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         ready,
   output logic         done_tick,
   output logic [N-1:0] sum,
   output logic         cout,
   output logic         ovf
);

   localparam int CHUNKS = N / K;
   localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
   localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);

   typedef enum logic [1:0] {IDLE, OP, DONE} state_t;

   state_t         state;
   state_t         state_next;
   logic [CW-1:0]  count;
   logic           carry;
   logic [N-1:0]   a_sh;
   logic [N-1:0]   b_sh;
   logic [N-1:0]   psum;
   logic           a_msb;
   logic           b_msb;
   logic [K:0]     chunk;
   logic [N-1:0]   psum_next;
   logic           last_chunk;

   // One K-bit slice of the addition; bit K is the carry into the next chunk.
   assign chunk = {1'b0, a_sh[K-1:0]} + {1'b0, b_sh[K-1:0]} + {{K{1'b0}}, carry};

   // Each finished chunk enters at the top, so after N/K steps the LSB chunk
   // has been pushed down to bit 0.
   generate
      if (K == N) begin : g_single
         assign psum_next = chunk[K-1:0];
      end else begin : g_multi
         assign psum_next = {chunk[K-1:0], psum[N-1:K]};
      end
   endgenerate

   assign last_chunk = (count == LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = OP;
         OP:      if (last_chunk) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign ready     = (state == IDLE);
   assign done_tick = (state == DONE);

   // The result registers are loaded on the final chunk edge so that they are
   // already valid during the DONE cycle in which done_tick is high.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
         carry <= 1'b0;
         a_sh  <= '0;
         b_sh  <= '0;
         psum  <= '0;
         a_msb <= 1'b0;
         b_msb <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= sub ? ~b : b;
                  carry <= sub | cin;
                  a_msb <= a[N-1];
                  b_msb <= sub ? ~b[N-1] : b[N-1];
                  count <= '0;
               end
            end
            OP: begin
               a_sh  <= a_sh >> K;
               b_sh  <= b_sh >> K;
               psum  <= psum_next;
               carry <= chunk[K];
               count <= count + 1'b1;
               if (last_chunk) begin
                  sum  <= psum_next;
                  cout <= chunk[K];
                  // Same-sign operands producing an opposite-sign result.
                  ovf  <= (a_msb == b_msb) && (psum_next[N-1] != a_msb);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
